// File: rtl/apb_sram_pkg.sv
// Shared types and constants for the APB-to-SRAM controller.
package apb_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/apb_sram_ctrl.sv
// APB slave turning each transfer into one SRAM word access with fixed read latency.
// Optional out-of-range error response is enabled by defining APB_SRAM_RANGE_CHK_EN.
module apb_sram_ctrl
  import apb_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wd_q, mem_wd_d;
  logic                mem_wen_q, mem_wen_d;
  logic                mem_ren_q, mem_ren_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  logic [ADDR_W-1:0]   idx_s;
  logic                range_err_s;
  logic                unused_s;

  assign idx_s = PADDR[ADDR_W+1:2];

`ifdef APB_SRAM_RANGE_CHK_EN
  // Reject words beyond the implemented depth and any aliasing through upper address bits.
  assign range_err_s = ({{(32-ADDR_W){1'b0}}, idx_s} >= 32'(DEPTH)) ||
                       ((PADDR >> (ADDR_W + 2)) != 32'd0);
  assign unused_s    = ^PADDR[1:0];
`else
  assign range_err_s = 1'b0;
  assign unused_s    = ^{PADDR[31:ADDR_W+2], PADDR[1:0]};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    mem_wen_d  = 1'b0;
    mem_ren_d  = 1'b0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = prdata_q;

    case (state_q)
      ST_IDLE: begin
        // Strobes are launched here so they appear registered in the ISSUE cycle.
        if (PSEL && !PENABLE) begin
          state_d    = ST_ISSUE;
          mem_addr_d = idx_s;
          mem_wd_d   = PWDATA;
          wr_d       = PWRITE;
          err_d      = range_err_s;
          mem_wen_d  = PWRITE & ~range_err_s;
          mem_ren_d  = ~PWRITE & ~range_err_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (err_q) begin
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          if (!wr_q) begin
            prdata_d = '0;
          end else begin
            prdata_d = prdata_q;
          end
        end else if (wr_q) begin
          state_d  = ST_RESP;
          pready_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d  = ST_RESP;
          cnt_d    = '0;
          prdata_d = mem_rd;
          pready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_wen_q  <= 1'b0;
      mem_ren_q  <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      mem_wen_q  <= mem_wen_d;
      mem_ren_q  <= mem_ren_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
    end
  end

  assign PRDATA   = prdata_q;
  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign mem_wen  = mem_wen_q;
  assign mem_ren  = mem_ren_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Randomized self-checking bench for apb_sram_ctrl with an SRAM model and a word-level reference memory.
module tb_apb_sram_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 768;
  localparam int RD_LAT = 3;
  localparam int WORDS  = 1 << ADDR_W;

  logic              PCLK = 1'b0;
  logic              PRESERN;
  logic              PSEL, PENABLE, PWRITE;
  logic [31:0]       PADDR;
  logic [DATA_W-1:0] PWDATA, PRDATA, mem_wd, mem_rd;
  logic              PREADY, PSLVERR, mem_wen, mem_ren;
  logic [ADDR_W-1:0] mem_addr;

  apb_sram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 PCLK = ~PCLK;

  // SRAM model: data appears RD_LAT cycles after the read strobe, garbage otherwise.
  logic [DATA_W-1:0] sram [WORDS];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  assign mem_rd = rd_pipe[RD_LAT-1];
  always @(posedge PCLK) begin
    if (mem_wen) sram[mem_addr] <= mem_wd;
    rd_pipe[0] <= mem_ren ? sram[mem_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model state
  logic [DATA_W-1:0] ref_mem [WORDS];
  logic [DATA_W-1:0] last_prdata;

  int n_vec = 0;
  int n_err = 0;

  // Per-transfer observations
  int                lat_o, wen_cnt, ren_cnt, strobe_cyc;
  logic [ADDR_W-1:0] strobe_addr;
  logic [DATA_W-1:0] strobe_wd, rdata_o;
  logic              err_o;

  function automatic bit is_oor(input logic [31:0] a);
`ifdef APB_SRAM_RANGE_CHK_EN
    return ((a >> 2) % WORDS >= DEPTH) || ((a >> (ADDR_W + 2)) != 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_cycle();
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [DATA_W-1:0] wd);
    int n;
    @(posedge PCLK); #1;
    n_vec++;
    if (PREADY !== 1'b0 || mem_wen !== 1'b0 || mem_ren !== 1'b0) begin
      n_err++;
      $display("FAIL setup_quiet addr=%h got rdy=%b wen=%b ren=%b want 0 0 0", addr, PREADY, mem_wen, mem_ren);
    end
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    wen_cnt = 0; ren_cnt = 0; strobe_cyc = -1; lat_o = -1; n = 0;
    while (lat_o < 0 && n < 20) begin
      @(posedge PCLK); #1;
      n++;
      PENABLE = 1'b1;
      if (mem_wen || mem_ren) begin
        wen_cnt += int'(mem_wen); ren_cnt += int'(mem_ren);
        strobe_cyc = n; strobe_addr = mem_addr; strobe_wd = mem_wd;
      end
      if (PREADY) begin
        lat_o = n; rdata_o = PRDATA; err_o = PSLVERR;
      end
    end
    if (lat_o < 0) begin
      n_vec++; n_err++;
      $display("FAIL timeout addr=%h got no PREADY within 20 cycles want PREADY", addr);
      PSEL = 1'b0; PENABLE = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({PREADY, PSLVERR, mem_wen, mem_ren} !== 4'b0000 || mem_addr !== '0 ||
        mem_wd !== '0 || PRDATA !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got rdy=%b err=%b wen=%b ren=%b addr=%h wd=%h rd=%h want all 0",
               PREADY, PSLVERR, mem_wen, mem_ren, mem_addr, mem_wd, PRDATA);
    end
  endtask

  task automatic test_fill();
    int bad = 0;
    for (int i = 0; i < WORDS; i++) begin
      logic [DATA_W-1:0] v = $urandom;
      logic [31:0] a = 32'(i) << 2;
      apb_xfer(1'b1, a, v);
      if (lat_o !== 2) bad++;
      if (!is_oor(a)) ref_mem[i] = v;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL fill_latency got %0d bad writes want 0", bad);
    end
  endtask

  task automatic test_directed();
    apb_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    ref_mem[4] = 32'hDEAD_BEEF;
    n_vec++;
    if (lat_o !== 2 || wen_cnt !== 1 || ren_cnt !== 0 || strobe_cyc !== 1 ||
        strobe_addr !== 10'd4 || strobe_wd !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL write_0x10 got lat=%0d wen=%0d ren=%0d cyc=%0d addr=%0d wd=%h want 2 1 0 1 4 deadbeef",
               lat_o, wen_cnt, ren_cnt, strobe_cyc, strobe_addr, strobe_wd);
    end
    n_vec++;
    if (PRDATA !== last_prdata) begin
      n_err++;
      $display("FAIL prdata_hold got %h want %h", PRDATA, last_prdata);
    end
    apb_xfer(1'b1, 32'h0000_0010, 32'hCAFE_F00D);
    ref_mem[4] = 32'hCAFE_F00D;
    apb_xfer(1'b0, 32'h0000_0010, 32'h0);
    last_prdata = 32'hCAFE_F00D;
    n_vec++;
    if (lat_o !== RD_LAT + 2 || ren_cnt !== 1 || wen_cnt !== 0 || strobe_cyc !== 1 ||
        strobe_addr !== 10'd4 || rdata_o !== 32'hCAFE_F00D || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL read_0x10 got lat=%0d ren=%0d cyc=%0d addr=%0d rd=%h err=%b want %0d 1 1 4 cafef00d 0",
               lat_o, ren_cnt, strobe_cyc, strobe_addr, rdata_o, err_o, RD_LAT + 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] v = $urandom;
    int t0, t1;
    t0 = $time;
    apb_xfer(1'b1, 32'h0000_0000, v);
    ref_mem[0] = v;
    n_vec++;
    if (lat_o !== 2 || wen_cnt !== 1) begin
      n_err++;
      $display("FAIL b2b_write got lat=%0d wen=%0d want 2 1", lat_o, wen_cnt);
    end
    apb_xfer(1'b0, 32'h0000_0004, 32'h0);
    t1 = $time;
    last_prdata = ref_mem[1];
    n_vec++;
    if (lat_o !== RD_LAT + 2 || rdata_o !== ref_mem[1] || (t1 - t0) !== 10 * (2 + RD_LAT + 2 + 2)) begin
      n_err++;
      $display("FAIL b2b_read got lat=%0d rd=%h span=%0d want %0d %h %0d",
               lat_o, rdata_o, t1 - t0, RD_LAT + 2, ref_mem[1], 10 * (RD_LAT + 6));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      logic              wr = 1'($urandom_range(0, 1));
      logic [31:0]       addr = (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
      logic [DATA_W-1:0] wd = $urandom;
      logic [ADDR_W-1:0] e_idx;
      logic [DATA_W-1:0] exp_rd;
      bit                oor;
      int                exp_lat;
      if ($urandom_range(0, 7) == 0) addr = addr | ($urandom & 32'hFFFF_F000);
      if ($urandom_range(0, 7) == 1) addr = 32'h0000_0C00;
      e_idx   = addr[ADDR_W+1:2];
      oor     = is_oor(addr);
      exp_lat = (wr || oor) ? 2 : RD_LAT + 2;
      exp_rd  = wr ? last_prdata : (oor ? '0 : ref_mem[e_idx]);
      apb_xfer(wr, addr, wd);
      n_vec++;
      if (lat_o !== exp_lat) begin
        n_err++;
        $display("FAIL rand_latency k=%0d got %0d want %0d", k, lat_o, exp_lat);
      end
      n_vec++;
      if (wen_cnt !== int'(wr && !oor) || ren_cnt !== int'(!wr && !oor)) begin
        n_err++;
        $display("FAIL rand_strobes k=%0d got wen=%0d ren=%0d want %0d %0d",
                 k, wen_cnt, ren_cnt, int'(wr && !oor), int'(!wr && !oor));
      end
      if (!oor) begin
        n_vec++;
        if (strobe_cyc !== 1 || strobe_addr !== e_idx || (wr && strobe_wd !== wd)) begin
          n_err++;
          $display("FAIL rand_mem_bus k=%0d got cyc=%0d addr=%0d wd=%h want 1 %0d %h",
                   k, strobe_cyc, strobe_addr, strobe_wd, e_idx, wd);
        end
      end
      n_vec++;
      if (rdata_o !== exp_rd || err_o !== oor) begin
        n_err++;
        $display("FAIL rand_resp k=%0d got rd=%h err=%b want %h %b", k, rdata_o, err_o, exp_rd, oor);
      end
      if (wr && !oor) ref_mem[e_idx] = wd;
      if (!wr) last_prdata = exp_rd;
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
  endtask

  task automatic test_range();
    apb_xfer(1'b0, 32'h0000_0C00, 32'h0);
    n_vec++;
`ifdef APB_SRAM_RANGE_CHK_EN
    if (lat_o !== 2 || wen_cnt !== 0 || ren_cnt !== 0 || err_o !== 1'b1 || rdata_o !== '0) begin
      n_err++;
      $display("FAIL range_0xC00 got lat=%0d ren=%0d err=%b rd=%h want 2 0 1 0", lat_o, ren_cnt, err_o, rdata_o);
    end
    last_prdata = '0;
`else
    if (lat_o !== RD_LAT + 2 || ren_cnt !== 1 || strobe_addr !== 10'd768 || err_o !== 1'b0 ||
        rdata_o !== ref_mem[768]) begin
      n_err++;
      $display("FAIL range_0xC00 got lat=%0d ren=%0d addr=%0d err=%b rd=%h want %0d 1 768 0 %h",
               lat_o, ren_cnt, strobe_addr, err_o, rdata_o, RD_LAT + 2, ref_mem[768]);
    end
    last_prdata = ref_mem[768];
`endif
  endtask

  task automatic test_abort();
    for (int d = 1; d <= 2; d++) begin
      int bad = 0;
      logic ren_seen = 1'b0;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0000_0008;
      for (int c = 1; c <= d; c++) begin
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (c == 1) ren_seen = mem_ren;
        if (c == d) begin PSEL = 1'b0; PENABLE = 1'b0; end
      end
      for (int c = 0; c < 6; c++) begin
        @(posedge PCLK); #1;
        if (PREADY || mem_wen || mem_ren) bad++;
      end
      n_vec++;
      if (ren_seen !== 1'b1 || bad !== 0 || PRDATA !== last_prdata) begin
        n_err++;
        $display("FAIL abort_d%0d got ren=%b bad=%0d rd=%h want 1 0 %h", d, ren_seen, bad, PRDATA, last_prdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0000_0020;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESERN = 1'b0;
    #2;
    n_vec++;
    if ({PREADY, PSLVERR, mem_wen, mem_ren} !== 4'b0000 || mem_addr !== '0 ||
        mem_wd !== '0 || PRDATA !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs got rdy=%b wen=%b ren=%b addr=%h rd=%h want all 0",
               PREADY, mem_wen, mem_ren, mem_addr, PRDATA);
    end
    last_prdata = '0;
    @(posedge PCLK); #1;
    PRESERN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge PCLK); #1;
      if (PREADY || mem_wen || mem_ren) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet got %0d active cycles want 0", bad);
    end
    apb_xfer(1'b0, 32'h0000_0020, 32'h0);
    last_prdata = ref_mem[8];
    n_vec++;
    if (lat_o !== RD_LAT + 2 || rdata_o !== ref_mem[8] || ren_cnt !== 1) begin
      n_err++;
      $display("FAIL reset_mid_read got lat=%0d rd=%h ren=%0d want %0d %h 1",
               lat_o, rdata_o, ren_cnt, RD_LAT + 2, ref_mem[8]);
    end
  endtask

  initial begin
    PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'h0; PWDATA = 32'h0;
    last_prdata = '0;
    repeat (3) @(posedge PCLK);
    #1;
    test_reset();
    PRESERN = 1'b1;
    test_fill();
    test_directed();
    test_back_to_back();
    test_random();
    test_range();
    test_abort();
    test_reset_mid();
    idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_sram_ctrl.md
APB_SRAM_CTRL -- requirements
Module: apb_sram_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, APB/SRAM data width; ADDR_W, default 10, SRAM word-address width; DEPTH, default 2**ADDR_W, implemented words (at most 2**ADDR_W); RD_LAT, default 1, SRAM read latency in cycles (1..4).
REQ-002 SHALL use one clock PCLK; reset PRESERN is asynchronous, active-low.
REQ-003 SHALL have these ports (name  direction  width  meaning):
  PCLK  in  1  clock
  PRESERN  in  1  async active-low reset
  PSEL  in  1  APB select
  PENABLE  in  1  APB access phase
  PWRITE  in  1  1=write, 0=read
  PADDR  in  32  byte address
  PWDATA  in  DATA_W  write data
  PRDATA  out  DATA_W  read data
  PREADY  out  1  transfer complete
  PSLVERR  out  1  transfer error
  mem_wen  out  1  SRAM write strobe
  mem_ren  out  1  SRAM read strobe
  mem_addr  out  ADDR_W  SRAM word address
  mem_wd  out  DATA_W  SRAM write data
  mem_rd  in  DATA_W  SRAM read data

Function
REQ-004 SHALL decode word index = PADDR[ADDR_W+1:2]; PADDR[1:0] ignored.
REQ-005 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-006 IDLE: on PSEL=1, PENABLE=0 (setup phase) SHALL latch index, PWDATA, PWRITE into mem_addr/mem_wd/direction and go to ISSUE; otherwise stay.
REQ-007 ISSUE (one cycle): exactly one of mem_wen/mem_ren SHALL be 1, per latched direction; write -> RESP; read -> WAIT with counter loaded to RD_LAT.
REQ-008 WAIT: counter SHALL decrement each cycle; in the cycle the counter reaches 1, mem_rd SHALL be captured into PRDATA at that edge and FSM goes to RESP.
REQ-009 RESP (one cycle): PREADY SHALL be 1; FSM returns to IDLE.
REQ-010 Latency from setup cycle to PREADY cycle SHALL be 2 cycles for a write and RD_LAT+2 cycles for a read.
REQ-011 Back-to-back transfers SHALL be accepted from the cycle after RESP with no idle cycle.
REQ-012 PRDATA SHALL hold its last captured value until the next read capture.
REQ-013 If PSEL falls in ISSUE or WAIT, FSM SHALL abort to IDLE without asserting PREADY; an already issued strobe is not retracted.
REQ-014 mem_wen, mem_ren and PREADY SHALL each be single-cycle pulses per transfer.

Reset
REQ-015 While PRESERN=0: FSM=IDLE; PREADY, PSLVERR, mem_wen, mem_ren, mem_addr, mem_wd, PRDATA and counter SHALL all be 0.
REQ-016 Reset asserted mid-transfer SHALL abandon the transfer immediately with no further strobes or PREADY.

Configuration
REQ-017 With APB_SRAM_RANGE_CHK_EN defined: index >= DEPTH, or any set PADDR bit above ADDR_W+1, SHALL give no mem strobe, ISSUE -> RESP directly, PSLVERR=1 and PREADY=1 together in RESP, PRDATA=0 for reads.
REQ-018 Without APB_SRAM_RANGE_CHK_EN: PSLVERR SHALL be constant 0; upper PADDR bits are ignored and the address wraps modulo 2**ADDR_W.

Structure
REQ-019 Shared package apb_sram_pkg SHALL hold the FSM state type, RD_LAT_MAX=4 and counter-width constant.
REQ-020 A single module SHALL hold all logic; no sub-module is required.

Verification
REQ-021 Write 0x0000_0010 <- 0xDEADBEEF: mem_wen=1, mem_addr=4, mem_wd=0xDEADBEEF in setup+1; PREADY=1 in setup+2.
REQ-022 Read 0x10 with RD_LAT=3, mem_rd=0xCAFEF00D: mem_ren in setup+1; PREADY=1, PRDATA=0xCAFEF00D in setup+5.
REQ-023 Back-to-back write 0x0 then read 0x4: second setup in the cycle after the first PREADY; both complete, no extra cycle.
REQ-024 Range check enabled, DEPTH=768, read 0xC00 (index 768): no strobe; PREADY=1, PSLVERR=1, PRDATA=0 in setup+2; disabled: mem_addr=768 wraps per REQ-018 and PSLVERR=0.
REQ-025 PRESERN pulsed low during WAIT: all outputs 0 immediately; after release, a normal read completes correctly.
